// File: rtl/point_commit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : point_commit_scheduler
// Description : Collects tracking-point updates from N_REQ producers into a
//               shadow point table. Round-robin arbitration selects one
//               producer per cycle. At every frame end the whole table is
//               streamed to pixel_manager, one entry per cycle in index
//               order, so a rendered frame never mixes points from two frames.
// Ports       : clk_in, rst_n_in        clock, async active-low reset
//               hcount_in, vcount_in    raster position (frame-end detect)
//               req_in/x_in/y_in/idx_in producer write requests, packed per r
//               grant_out               one-hot combinational grant
//               pt_*_out                registered point beats
//               frame_commit_out        one-cycle pulse after the last beat
//               busy_out, overrun_out   commit in progress / sticky overrun
// Config      : `define POINT_CLAMP_EN saturates written x/y to H_MAX/V_MAX
//               and adds one cycle of write latency.
// Revision    : 1.0  initial release
// ============================================================================
module point_commit_scheduler #(
  parameter int N_REQ             = 2,
  parameter int N_TRACKING_POINTS = 4,
  parameter int H_LAST            = 320,
  parameter int V_LAST            = 640,
  parameter int H_MAX             = 1279,
  parameter int V_MAX             = 719,
  localparam int IDX_W = (N_TRACKING_POINTS > 1) ? $clog2(N_TRACKING_POINTS) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*11-1:0]    x_in,
  input  logic [N_REQ*10-1:0]    y_in,
  input  logic [N_REQ*IDX_W-1:0] idx_in,
  output logic [N_REQ-1:0]       grant_out,
  output logic                   pt_valid_out,
  output logic [IDX_W-1:0]       pt_idx_out,
  output logic [10:0]            pt_x_out,
  output logic [9:0]             pt_y_out,
  output logic                   pt_fresh_out,
  output logic                   frame_commit_out,
  output logic                   busy_out,
  output logic                   overrun_out
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                       r_state, w_state_nxt;
  logic   [IDX_W-1:0]           r_cnt;
  logic                         r_match, r_eof, w_match, w_last;
  logic   [RR_W-1:0]            r_rr_ptr, w_gnt_idx;
  logic                         w_gnt_any;
  logic   [N_REQ-1:0]           w_grant;
  logic   [10:0]                r_tab_x [N_TRACKING_POINTS];
  logic   [9:0]                 r_tab_y [N_TRACKING_POINTS];
  logic   [N_TRACKING_POINTS-1:0] r_fresh;
  logic   [10:0]                w_sel_x, w_wr_x, w_rd_x;
  logic   [9:0]                 w_sel_y, w_wr_y, w_rd_y;
  logic   [IDX_W-1:0]           w_sel_idx, w_wr_idx;
  logic                         w_idx_ok, w_wr_en, w_bypass, w_rd_fresh;

  // Frame end: only the first cycle of a (possibly held) raster match counts.
  assign w_match = (hcount_in == 11'(H_LAST)) && (vcount_in == 10'(V_LAST));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_match <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_match <= w_match;
      r_eof   <= w_match & ~r_match;
    end
  end

  // Round-robin search starting at r_rr_ptr; only enabled while idle.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (r_state == S_IDLE) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_gnt_any && req_in[(int'(r_rr_ptr) + i) % N_REQ]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = RR_W'((int'(r_rr_ptr) + i) % N_REQ);
        end
      end
    end
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
  end

  assign grant_out = w_grant;
  assign w_sel_x   = x_in[w_gnt_idx*11 +: 11];
  assign w_sel_y   = y_in[w_gnt_idx*10 +: 10];
  assign w_sel_idx = idx_in[w_gnt_idx*IDX_W +: IDX_W];
  // Out-of-range targets are still granted (the producer is released) but dropped.
  assign w_idx_ok  = int'(w_sel_idx) < N_TRACKING_POINTS;

`ifdef POINT_CLAMP_EN
  logic             r_wr_vld;
  logic [IDX_W-1:0] r_wr_idx;
  logic [10:0]      r_wr_x;
  logic [9:0]       r_wr_y;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_vld <= 1'b0;
      r_wr_idx <= '0;
      r_wr_x   <= '0;
      r_wr_y   <= '0;
    end else begin
      r_wr_vld <= w_gnt_any & w_idx_ok;
      r_wr_idx <= w_sel_idx;
      r_wr_x   <= (w_sel_x > 11'(H_MAX)) ? 11'(H_MAX) : w_sel_x;
      r_wr_y   <= (w_sel_y > 10'(V_MAX)) ? 10'(V_MAX) : w_sel_y;
    end
  end

  assign w_wr_en  = r_wr_vld;
  assign w_wr_idx = r_wr_idx;
  assign w_wr_x   = r_wr_x;
  assign w_wr_y   = r_wr_y;
`else
  assign w_wr_en  = w_gnt_any & w_idx_ok;
  assign w_wr_idx = w_sel_idx;
  assign w_wr_x   = w_sel_x;
  assign w_wr_y   = w_sel_y;
`endif

  // A write still in flight when the commit reaches its entry is forwarded,
  // so a write granted on the frame-end edge belongs to that commit.
  assign w_bypass   = w_wr_en && (w_wr_idx == r_cnt);
  assign w_rd_x     = w_bypass ? w_wr_x : r_tab_x[r_cnt];
  assign w_rd_y     = w_bypass ? w_wr_y : r_tab_y[r_cnt];
  assign w_rd_fresh = w_bypass | r_fresh[r_cnt];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_TRACKING_POINTS; i++) begin
        r_tab_x[i] <= '0;
        r_tab_y[i] <= '0;
      end
      r_fresh <= '0;
    end else begin
      if (r_state == S_DONE) r_fresh <= '0;
      else if (w_wr_en)      r_fresh[w_wr_idx] <= 1'b1;
      if (w_wr_en) begin
        r_tab_x[w_wr_idx] <= w_wr_x;
        r_tab_y[w_wr_idx] <= w_wr_y;
      end
    end
  end

  assign w_last = int'(r_cnt) == (N_TRACKING_POINTS - 1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_eof)  w_state_nxt = S_COMMIT;
      S_COMMIT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:               w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  assign busy_out = (r_state == S_COMMIT);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt            <= '0;
      r_rr_ptr         <= '0;
      pt_valid_out     <= 1'b0;
      pt_idx_out       <= '0;
      pt_x_out         <= '0;
      pt_y_out         <= '0;
      pt_fresh_out     <= 1'b0;
      frame_commit_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      pt_valid_out     <= 1'b0;
      frame_commit_out <= 1'b0;
      if (w_gnt_any) r_rr_ptr <= RR_W'((int'(w_gnt_idx) + 1) % N_REQ);
      if (r_eof && (r_state != S_IDLE)) overrun_out <= 1'b1;
      case (r_state)
        S_IDLE: r_cnt <= '0;
        S_COMMIT: begin
          pt_valid_out <= 1'b1;
          pt_idx_out   <= r_cnt;
          pt_x_out     <= w_rd_x;
          pt_y_out     <= w_rd_y;
          pt_fresh_out <= w_rd_fresh;
          r_cnt        <= r_cnt + 1'b1;
        end
        S_DONE: frame_commit_out <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
